// File: rtl/jhi_pwm_generator_if.sv
// TinyTapeout-style pin bundle for the PWM generator: design select,
// dedicated inputs, bidirectional pins and dedicated outputs.
interface jhi_pwm_generator_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/jhi_pwm_generator.sv
// 8-bit prescaled PWM with complementary output and period strobe.
// Optional dead-time insertion is enabled by defining PWM_DEADTIME_EN.
module jhi_pwm_generator (
  input  logic                  clk,
  input  logic                  rst,
  jhi_pwm_generator_if.slave    bus
);

  logic       run, pol;
  logic [2:0] psel;
  logic [6:0] pre, mask;
  logic [7:0] cnt, duty_q;
  logic       tick, wrap, raw, lvl;
  logic       pwm_nxt, pwmn_nxt;
  logic       pwm_q, pwmn_q, strobe_q;

  assign run  = bus.uio_in[0];
  assign psel = bus.uio_in[3:1];
  assign pol  = bus.uio_in[4];

  // Low psel bits of pre all ones -> one tick every 2^psel clocks.
  assign mask = 7'((8'd1 << psel) - 8'd1);
  assign tick = run && ((pre & mask) == mask);
  assign wrap = tick && (cnt == 8'hFF);
  assign raw  = cnt < duty_q;
  assign lvl  = raw ^ pol;

`ifdef PWM_DEADTIME_EN
  logic       lvl_q;
  logic [2:0] dt_q, dt_nxt;

  // A level change reloads the gap; both outputs stay low until it drains.
  always_comb begin
    dt_nxt = (dt_q != 3'd0) ? dt_q - 3'd1 : 3'd0;
    if (lvl != lvl_q) dt_nxt = bus.uio_in[7:5];
  end

  assign pwm_nxt  =  lvl && (dt_nxt == 3'd0);
  assign pwmn_nxt = !lvl && (dt_nxt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b0;
      dt_q  <= 3'd0;
    end else if (bus.ena) begin
      if (!run) begin
        lvl_q <= 1'b0;
        dt_q  <= 3'd0;
      end else begin
        lvl_q <= lvl;
        dt_q  <= dt_nxt;
      end
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^bus.uio_in[7:5];
  assign pwm_nxt   = lvl;
  assign pwmn_nxt  = ~lvl;
`endif

  // Everything freezes while the design is deselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= 7'd0;
      cnt      <= 8'd0;
      duty_q   <= 8'd0;
      pwm_q    <= 1'b0;
      pwmn_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else if (bus.ena) begin
      if (!run) begin
        pre      <= 7'd0;
        cnt      <= 8'd0;
        duty_q   <= bus.ui_in;
        pwm_q    <= 1'b0;
        pwmn_q   <= 1'b0;
        strobe_q <= 1'b0;
      end else begin
        pre      <= pre + 7'd1;
        if (tick) cnt <= cnt + 8'd1;
        // Duty only reloads at the wrap so a period is never split.
        if (wrap) duty_q <= bus.ui_in;
        pwm_q    <= pwm_nxt;
        pwmn_q   <= pwmn_nxt;
        strobe_q <= wrap;
      end
    end
  end

  assign bus.uo_out  = {cnt[7:3], bus.ena ? {strobe_q, pwmn_q, pwm_q} : 3'b000};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_jhi_pwm_generator.sv
// Directed-vector bench for jhi_pwm_generator: duty, polarity, prescale,
// mid-period duty change, ena hold, reset during run, optional dead-time.
module tb_jhi_pwm_generator;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0, n_err = 0;
  int   m_hi, m_hin, m_ns, m_fs, m_both;

  jhi_pwm_generator_if bus ();
  jhi_pwm_generator dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample n negedges: pwm highs, pwmn highs, strobes, first strobe index, overlaps.
  task automatic measure(input int n);
    m_hi = 0; m_hin = 0; m_ns = 0; m_fs = 0; m_both = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.uo_out[0]) m_hi++;
      if (bus.uo_out[1]) m_hin++;
      if (bus.uo_out[0] && bus.uo_out[1]) m_both++;
      if (bus.uo_out[2]) begin
        m_ns++;
        if (m_fs == 0) m_fs = k;
      end
    end
  endtask

  // Stop, load duty/config, confirm idle outputs, then start; next negedge is sample 1.
  task automatic start(input logic [7:0] d, input logic [2:0] p, input logic pol,
                       input logic [2:0] t, input string tag);
    @(negedge clk);
    bus.ui_in  = d;
    bus.uio_in = {t, pol, p, 1'b0};
    repeat (2) @(negedge clk);
    check_vec({tag, "_idle"}, int'(bus.uo_out[2:0]), 0);
    bus.uio_in[0] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; bus.ena = 1'b0; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
    repeat (2) @(negedge clk);
    check_vec("rst_uo",  int'(bus.uo_out), 0);
    check_vec("rst_uio", int'(bus.uio_out), 0);
    check_vec("rst_oe",  int'(bus.uio_oe), 0);
    rst = 1'b0; bus.ena = 1'b1;

    // D=64, P=0: 64 high / 192 low, strobe on sample 256.
    start(8'd64, 3'd0, 1'b0, 3'd0, "d64");
    measure(10);
    check_vec("d64_cnt10", int'(bus.uo_out[7:3]), 1);
    measure(246);
    check_vec("d64_hi_a", m_hi, 54);
    check_vec("d64_fs_a", m_fs, 246);
    measure(256);
    check_vec("d64_hi",   m_hi, 64);
    check_vec("d64_hin",  m_hin, 192);
    check_vec("d64_ns",   m_ns, 1);
    check_vec("d64_fs",   m_fs, 256);

    // Duty change mid-period lands one period later.
    measure(100);
    check_vec("chg_hi_a", m_hi, 64);
    bus.ui_in = 8'd192;
    measure(156);
    check_vec("chg_hi_b", m_hi, 0);
    check_vec("chg_fs_b", m_fs, 156);
    measure(256);
    check_vec("chg_hi_c", m_hi, 192);
    check_vec("chg_hin_c", m_hin, 64);

    start(8'd0, 3'd0, 1'b0, 3'd0, "d0");
    measure(256);
    check_vec("d0_hi",  m_hi, 0);
    check_vec("d0_hin", m_hin, 256);

    start(8'd255, 3'd0, 1'b0, 3'd0, "d255");
    measure(256);
    check_vec("d255_hi",  m_hi, 255);
    check_vec("d255_hin", m_hin, 1);

    start(8'd64, 3'd0, 1'b1, 3'd0, "pol");
    measure(256);
    check_vec("pol_hi",  m_hi, 192);
    check_vec("pol_hin", m_hin, 64);

    // P=2, D=128: 512 high / 512 low, strobe every 1024.
    start(8'd128, 3'd2, 1'b0, 3'd0, "p2");
    measure(1024);
    check_vec("p2_hi", m_hi, 512);
    check_vec("p2_ns", m_ns, 1);
    check_vec("p2_fs", m_fs, 1024);

    // ena low holds cnt/pre and forces uo_out[2:0] low.
    start(8'd64, 3'd0, 1'b0, 3'd0, "ena");
    measure(10);
    bus.ena = 1'b0;
    repeat (5) @(negedge clk);
    check_vec("ena_lo_out", int'(bus.uo_out[2:0]), 0);
    check_vec("ena_lo_cnt", int'(bus.uo_out[7:3]), 1);
    bus.ena = 1'b1;
    measure(246);
    check_vec("ena_hi", m_hi, 54);
    check_vec("ena_fs", m_fs, 246);

    // Reset while running: first period low, new duty applies afterwards.
    bus.ui_in = 8'd200;
    rst = 1'b1;
    @(negedge clk);
    check_vec("rst_run_uo", int'(bus.uo_out), 0);
    rst = 1'b0;
    measure(256);
    check_vec("rst_run_hi0", m_hi, 0);
    check_vec("rst_run_fs",  m_fs, 256);
    measure(256);
    check_vec("rst_run_hi1", m_hi, 200);

`ifdef PWM_DEADTIME_EN
    start(8'd64, 3'd0, 1'b0, 3'd3, "dt3");
    measure(256);
    check_vec("dt3_hi",   m_hi, 61);
    check_vec("dt3_hin",  m_hin, 189);
    check_vec("dt3_both", m_both, 0);
    measure(256);
    check_vec("dt3_hi2",  m_hi, 61);
    check_vec("dt3_both2", m_both, 0);
`else
    // Dead-time field must be ignored without the feature.
    start(8'd64, 3'd0, 1'b0, 3'd7, "dtoff");
    measure(256);
    check_vec("dtoff_hi",  m_hi, 64);
    check_vec("dtoff_hin", m_hin, 192);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
